fc_obuf_reader: RTL and testbench

FC_OBUF_READER -- requirements
Module: fc_obuf_reader

---
 rtl/fc_obuf_reader.sv | 132 +++++++++++++
 tb/tb_fc_obuf_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fc_obuf_reader.sv
// fc_obuf_reader
//   Drains the CIM output buffers of a fully-connected layer into the input
//   buffer of the next layer. For each output neuron it reads one signed
//   partial sum per vertical CIM tile and adds them. It then applies ReLU,
//   requantises the result with an arithmetic right shift, saturates it to
//   DATA_SIZE bits and writes it out, honouring the next layer's ready signal.
//
// Ports
//   clk            : clock; all logic is updated on its rising edge
//   rst            : synchronous, active-high reset
//   i_start        : CIM output buffers are valid; start a drain run
//   o_ready        : block is idle, so i_start will be accepted
//   o_cim_rd_addr  : read address to the CIM output buffers (the neuron index)
//   i_data         : one signed partial sum per tile; tile t is at
//                    [t*OBUF_DATA_SIZE +: OBUF_DATA_SIZE]
//   i_next_ready   : next-layer input buffer can accept a write
//   o_ibuf_we      : write strobe into the next-layer input buffer
//   o_ibuf_wr_data : requantised activation for that write
//   o_done         : one-cycle pulse when the run completes
module fc_obuf_reader #(
    parameter int OUTPUT_NEURONS = 10,
    parameter int V_CIM_TILES    = 2,
    parameter int XBAR_SIZE      = 512,
    parameter int OBUF_DATA_SIZE = 16,
    parameter int DATA_SIZE      = 8,
    parameter int SHIFT          = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_start,
    output logic                                  o_ready,
    output logic [$clog2(XBAR_SIZE)-1:0]          o_cim_rd_addr,
    input  logic [V_CIM_TILES*OBUF_DATA_SIZE-1:0] i_data,
    input  logic                                  i_next_ready,
    output logic                                  o_ibuf_we,
    output logic [DATA_SIZE-1:0]                  o_ibuf_wr_data,
    output logic                                  o_done
);

    localparam int ADDR_W = $clog2(XBAR_SIZE);
    // Enough headroom that adding V_CIM_TILES signed values cannot overflow.
    localparam int SUM_W  = OBUF_DATA_SIZE + $clog2(V_CIM_TILES) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << DATA_SIZE) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic              last_neuron;
    logic signed [SUM_W-1:0] sum_p0;

    function automatic logic signed [SUM_W-1:0] sign_ext(input logic [OBUF_DATA_SIZE-1:0] v);
        return {{(SUM_W-OBUF_DATA_SIZE){v[OBUF_DATA_SIZE-1]}}, v};
    endfunction

    // ReLU, then arithmetic shift, then clamp to the unsigned activation range.
    function automatic logic [DATA_SIZE-1:0] relu_shift_sat(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] sh;
        sh = s >>> SHIFT;
        if (s < 0)
            return '0;
        else if (sh > SAT_MAX)
            return '1;
        else
            return sh[DATA_SIZE-1:0];
    endfunction

    assign last_neuron   = (idx == ADDR_W'(OUTPUT_NEURONS - 1));
    assign o_cim_rd_addr = idx;

    // Stage p0: tile partial sums arriving in CAPTURE, summed combinationally
    always_comb begin
        sum_p0 = '0;
        for (int t = 0; t < V_CIM_TILES; t++)
            sum_p0 = sum_p0 + sign_ext(i_data[t*OBUF_DATA_SIZE +: OBUF_DATA_SIZE]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = ADDR;
            ADDR:    state_next = CAPTURE;
            CAPTURE: state_next = WRITE;
            WRITE:   if (i_next_ready) state_next = last_neuron ? DONE : ADDR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_ready   = (state == IDLE);
        o_ibuf_we = (state == WRITE) && i_next_ready;
        o_done    = (state == DONE);
    end

    // Neuron index; it is also the read address, so it only moves after an
    // accepted write and stays put while the next layer back-pressures.
    always_ff @(posedge clk) begin
        if (rst)
            idx <= '0;
        else if (state == IDLE && i_start)
            idx <= '0;
        else if (state == WRITE && i_next_ready && !last_neuron)
            idx <= idx + 1'b1;
    end

    // Stage p1: requantised activation, held until the write is accepted
    always_ff @(posedge clk) begin
        if (rst)
            o_ibuf_wr_data <= '0;
        else if (state == CAPTURE)
            o_ibuf_wr_data <= relu_shift_sat(sum_p0);
    end

endmodule

// File: tb/tb_fc_obuf_reader.sv
// Testbench for fc_obuf_reader with default parameters. A small registered
// memory stands in for the CIM output buffers, with one cycle of read latency.
module tb_fc_obuf_reader;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        o_ready;
    logic [8:0]  o_cim_rd_addr;
    logic [31:0] i_data;
    logic        i_next_ready;
    logic        o_ibuf_we;
    logic [7:0]  o_ibuf_wr_data;
    logic        o_done;

    logic [15:0] mem0 [16];
    logic [15:0] mem1 [16];

    int n_vec = 0;
    int n_err = 0;

    // Hand-computed activations for neurons 0..9 (see the memory contents below)
    int exp_data [10] = '{10, 0, 255, 0, 0, 255, 255, 0, 255, 3};

    fc_obuf_reader dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .o_ready        (o_ready),
        .o_cim_rd_addr  (o_cim_rd_addr),
        .i_data         (i_data),
        .i_next_ready   (i_next_ready),
        .o_ibuf_we      (o_ibuf_we),
        .o_ibuf_wr_data (o_ibuf_wr_data),
        .o_done         (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        i_data <= {mem1[o_cim_rd_addr[3:0]], mem0[o_cim_rd_addr[3:0]]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int waited;
        logic seen_done;
        logic exp_we;

        rst          = 1'b1;
        i_start      = 1'b0;
        i_next_ready = 1'b1;
        i_data       = '0;
        for (int i = 0; i < 16; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[0] = 16'(100);    mem1[0] = 16'(60);      // 160>>4 = 10
        mem0[1] = 16'(-200);   mem1[1] = 16'(50);      // negative -> 0
        mem0[2] = 16'(30000);  mem1[2] = 16'(30000);   // 3750 -> 255
        mem0[3] = 16'(-1);     mem1[3] = 16'(-1);      // -2 -> 0
        mem0[4] = 16'(15);     mem1[4] = 16'(0);       // 15>>4 = 0
        mem0[5] = 16'(4095);   mem1[5] = 16'(0);       // 255, no clamp
        mem0[6] = 16'(4096);   mem1[6] = 16'(0);       // 256 -> 255
        mem0[7] = 16'(-32768); mem1[7] = 16'(32767);   // -1 -> 0
        mem0[8] = 16'(32767);  mem1[8] = 16'(32767);   // 4095 -> 255
        mem0[9] = 16'(32);     mem1[9] = 16'(16);      // 48>>4 = 3

        // Reset held for two edges
        tick();
        tick();
        check("rst_ready", 32'(o_ready), 1);
        check("rst_we",    32'(o_ibuf_we), 0);
        check("rst_done",  32'(o_done), 0);
        check("rst_addr",  32'(o_cim_rd_addr), 0);
        check("rst_data",  32'(o_ibuf_wr_data), 0);
        rst = 1'b0;
        tick();

        // Full run, no back-pressure: i_start in cycle 0
        i_start = 1'b1;
        #1;
        check("run_ready0", 32'(o_ready), 1);
        pulses = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            i_start = 1'b0;
            #1;
            exp_we = (k >= 3 && k <= 30 && (k % 3) == 0);
            check($sformatf("run_we_c%0d", k), 32'(o_ibuf_we), 32'(exp_we));
            if (o_ibuf_we) pulses++;
            if (exp_we) begin
                check($sformatf("run_addr_c%0d", k), 32'(o_cim_rd_addr), 32'(k / 3 - 1));
                check($sformatf("run_data_c%0d", k), 32'(o_ibuf_wr_data), 32'(exp_data[k / 3 - 1]));
            end
            check($sformatf("run_done_c%0d", k), 32'(o_done), 32'(k == 31));
            if (k == 32) check("run_ready32", 32'(o_ready), 1);
        end
        check("run_pulses", 32'(pulses), 10);

        // Back-pressure on the first write of a run
        i_next_ready = 1'b0;
        i_start      = 1'b1;
        #1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            i_start = 1'b0;
            #1;
            if (k >= 3) begin
                check($sformatf("bp_we_c%0d", k),   32'(o_ibuf_we), 0);
                check($sformatf("bp_data_c%0d", k), 32'(o_ibuf_wr_data), 10);
                check($sformatf("bp_addr_c%0d", k), 32'(o_cim_rd_addr), 0);
            end
        end
        tick();
        i_next_ready = 1'b1;
        #1;
        check("bp_release_we",   32'(o_ibuf_we), 1);
        check("bp_release_data", 32'(o_ibuf_wr_data), 10);
        check("bp_release_addr", 32'(o_cim_rd_addr), 0);
        tick();
        #1;
        check("bp_after_we",   32'(o_ibuf_we), 0);
        check("bp_after_addr", 32'(o_cim_rd_addr), 1);

        seen_done = 1'b0;
        waited    = 0;
        while (!seen_done && waited < 40) begin
            tick();
            #1;
            waited++;
            if (o_done) seen_done = 1'b1;
        end
        check("bp_done_seen", 32'(seen_done), 1);
        tick();
        #1;
        check("bp_ready_after", 32'(o_ready), 1);

        // Ignored start in cycle 5, reset in cycle 10
        i_start = 1'b1;
        #1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            i_start = (k == 5);
            rst     = (k == 10);
            #1;
            check($sformatf("mr_done_c%0d", k), 32'(o_done), 0);
            if (k == 6) begin
                check("mr_we_c6",   32'(o_ibuf_we), 1);
                check("mr_addr_c6", 32'(o_cim_rd_addr), 1);
                check("mr_data_c6", 32'(o_ibuf_wr_data), 0);
            end
            if (k == 9) begin
                check("mr_we_c9",   32'(o_ibuf_we), 1);
                check("mr_data_c9", 32'(o_ibuf_wr_data), 255);
            end
            if (k >= 11) begin
                check($sformatf("mr_ready_c%0d", k), 32'(o_ready), 1);
                check($sformatf("mr_addr_c%0d", k),  32'(o_cim_rd_addr), 0);
                check($sformatf("mr_we_c%0d", k),    32'(o_ibuf_we), 0);
                check($sformatf("mr_data_c%0d", k),  32'(o_ibuf_wr_data), 0);
            end
        end

        // Reset beats a simultaneous start
        rst     = 1'b1;
        i_start = 1'b1;
        tick();
        rst     = 1'b0;
        i_start = 1'b0;
        #1;
        check("prio_ready", 32'(o_ready), 1);
        check("prio_addr",  32'(o_cim_rd_addr), 0);
        tick();
        #1;
        check("prio_ready2", 32'(o_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
